fir_sym_stream: RTL and testbench

Parametrised symmetric (linear-phase) FIR filter with a streaming valid/ready interface, runtime-loadable double-buffered coefficients and a three-stage pipelined datapath. It replaces the fixed 20-tap, hard-coded-coefficient filter in the signal chain. It sits between the sample source and the downstream decimator/DAC path, and tolerates backpressure from either side.

---
 rtl/fir_pkg.sv | 40 ++++
 rtl/fir_coef_bank.sv | 51 +++++
 rtl/fir_sym_stream.sv | 164 ++++++++++++++++
 tb/tb_fir_sym_stream.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared constants and width helpers for the symmetric streaming FIR.
// Optional build macro: FIR_SAT_EN (saturating output reduction).
package fir_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_COEF_W = 16;
  localparam int DEF_NTAPS  = 20;
  localparam int DEF_SHIFT  = 12;

  // Smallest r such that 2**r >= value (0 for value <= 1).
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  // Number of unique coefficients of a symmetric filter.
  function automatic int half_taps(input int ntaps);
    return ntaps / 2;
  endfunction

  // Pre-adder result: sum of two samples needs one extra bit.
  function automatic int pre_w(input int data_w);
    return data_w + 1;
  endfunction

  // Product of a pre-added sample and a coefficient.
  function automatic int prod_w(input int data_w, input int coef_w);
    return data_w + coef_w + 1;
  endfunction

  // Sum of NHALF products without overflow.
  function automatic int acc_w(input int data_w, input int coef_w, input int ntaps);
    return prod_w(data_w, coef_w) + clog2(half_taps(ntaps));
  endfunction

endpackage

// File: rtl/fir_coef_bank.sv
// Double-buffered coefficient store: writes land in the shadow bank, a
// commit copies the shadow bank (including a same-cycle write) into the
// active bank. Out-of-range addresses are ignored.
module fir_coef_bank
  import fir_pkg::*;
#(
  parameter int COEF_W = DEF_COEF_W,
  parameter int NHALF  = DEF_NTAPS / 2,
  parameter int AW     = clog2(DEF_NTAPS / 2)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      we,
  input  logic [AW-1:0]             addr,
  input  logic [COEF_W-1:0]         wdata,
  input  logic                      commit,
  output logic [NHALF*COEF_W-1:0]   active
);

  logic [COEF_W-1:0] shadow_q [NHALF];
  logic [COEF_W-1:0] shadow_d [NHALF];
  logic [COEF_W-1:0] active_q [NHALF];

  // Index decode: only an exact match on a valid entry takes the write.
  always_comb begin
    shadow_d = shadow_q;
    for (int k = 0; k < NHALF; k++) begin
      if (we && (int'(addr) == k)) shadow_d[k] = wdata;
    end
  end

  // Shadow holds pending writes; active only changes on commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NHALF; k++) begin
        shadow_q[k] <= '0;
        active_q[k] <= '0;
      end
    end else begin
      shadow_q <= shadow_d;
      if (commit) active_q <= shadow_d;
    end
  end

  // Flatten the active bank, entry k in bits [k*COEF_W +: COEF_W].
  always_comb begin
    active = '0;
    for (int k = 0; k < NHALF; k++) active[k*COEF_W +: COEF_W] = active_q[k];
  end

endmodule

// File: rtl/fir_sym_stream.sv
// Symmetric linear-phase FIR with valid/ready streaming and a pipelined
// datapath: delay line -> pre-add -> multiply -> sum/scale/output.
// Optional build macro: FIR_SAT_EN selects a saturating output reduction
// and drives out_sat; without it the output wraps and out_sat is 0.
//
// Handshake: a sample transfers on a rising edge where in_valid && in_ready;
// an output transfers where out_valid && out_ready. Once out_valid is high
// out_data is held until it transfers. in_ready drops only while the output
// register is full and not being taken, and then every stage freezes.
module fir_sym_stream
  import fir_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int COEF_W = DEF_COEF_W,
  parameter int NTAPS  = DEF_NTAPS,
  parameter int SHIFT  = DEF_SHIFT
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [DATA_W-1:0]                   in_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [DATA_W-1:0]                   out_data,
  output logic                                out_sat,
  input  logic                                coef_we,
  input  logic [clog2(half_taps(NTAPS))-1:0]  coef_addr,
  input  logic [COEF_W-1:0]                   coef_wdata,
  input  logic                                coef_commit
);

  localparam int NHALF = half_taps(NTAPS);
  localparam int AW    = clog2(NHALF);
  localparam int PW    = pre_w(DATA_W);
  localparam int MW    = prod_w(DATA_W, COEF_W);
  localparam int ACCW  = acc_w(DATA_W, COEF_W, NTAPS);

  logic stall;
  logic accept;

  logic signed [DATA_W-1:0] line_q [NTAPS];
  logic                     line_valid;
  logic signed [PW-1:0]     pre_q  [NHALF];
  logic                     s1_valid;
  logic signed [MW-1:0]     prod_q [NHALF];
  logic                     s2_valid;

  logic [NHALF*COEF_W-1:0]  active_flat;
  logic signed [COEF_W-1:0] coef [NHALF];
  logic signed [ACCW-1:0]   acc;
  logic [DATA_W-1:0]        res;

  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;
  assign accept   = in_valid && in_ready;

  fir_coef_bank #(
    .COEF_W (COEF_W),
    .NHALF  (NHALF),
    .AW     (AW)
  ) u_coef_bank (
    .clk    (clk),
    .rst    (rst),
    .we     (coef_we),
    .addr   (coef_addr),
    .wdata  (coef_wdata),
    .commit (coef_commit),
    .active (active_flat)
  );

  // Unpack the active coefficients as signed values.
  always_comb begin
    for (int k = 0; k < NHALF; k++) coef[k] = active_flat[k*COEF_W +: COEF_W];
  end

  // Delay line: shift in on accept; line_valid marks a freshly shifted line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NTAPS; k++) line_q[k] <= '0;
      line_valid <= 1'b0;
    end else if (!stall) begin
      line_valid <= accept;
      if (accept) begin
        line_q[0] <= in_data;
        for (int k = 1; k < NTAPS; k++) line_q[k] <= line_q[k-1];
      end
    end
  end

  // Stage 1: fold the symmetric taps with a pre-adder.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NHALF; k++) pre_q[k] <= '0;
      s1_valid <= 1'b0;
    end else if (!stall) begin
      for (int k = 0; k < NHALF; k++) begin
        pre_q[k] <= PW'(line_q[k]) + PW'(line_q[NTAPS-1-k]);
      end
      s1_valid <= line_valid;
    end
  end

  // Stage 2: multiply by the active coefficients sampled on this edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NHALF; k++) prod_q[k] <= '0;
      s2_valid <= 1'b0;
    end else if (!stall) begin
      for (int k = 0; k < NHALF; k++) prod_q[k] <= MW'(pre_q[k]) * MW'(coef[k]);
      s2_valid <= s1_valid;
    end
  end

  // Full-precision sum of the products.
  always_comb begin
    acc = '0;
    for (int k = 0; k < NHALF; k++) acc = acc + ACCW'(prod_q[k]);
  end

`ifdef FIR_SAT_EN
  localparam logic signed [ACCW-1:0] MAX_V = {{(ACCW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACCW-1:0] MIN_V = {{(ACCW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  logic signed [ACCW-1:0] scaled;
  logic                   clip;

  assign scaled = acc >>> SHIFT;

  // Clamp the scaled sum into the output range and flag any clipping.
  always_comb begin
    res  = DATA_W'(scaled);
    clip = 1'b0;
    if (scaled > MAX_V) begin
      res  = MAX_V[DATA_W-1:0];
      clip = 1'b1;
    end else if (scaled < MIN_V) begin
      res  = MIN_V[DATA_W-1:0];
      clip = 1'b1;
    end
  end

  // Clip flag travels with out_data and holds with it during a stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) out_sat <= 1'b0;
    else if (!stall) out_sat <= clip;
  end
`else
  assign res     = DATA_W'(acc >>> SHIFT);
  assign out_sat = 1'b0;
`endif

  // Stage 3: output register, held while downstream is not ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (!stall) begin
      out_data  <= res;
      out_valid <= s2_valid;
    end
  end

endmodule

// File: tb/tb_fir_sym_stream.sv
// Directed bench for fir_sym_stream (default parameters).
module tb_fir_sym_stream;

  localparam int DATA_W = 16;
  localparam int COEF_W = 16;
  localparam int NTAPS  = 20;
  localparam int NHALF  = 10;
  localparam int SHIFT  = 12;
  localparam int AW     = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_sat;
  logic              coef_we;
  logic [AW-1:0]     coef_addr;
  logic [COEF_W-1:0] coef_wdata;
  logic              coef_commit;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  int c1[NHALF] = '{-21, 8, 34, 79, 143, 220, 302, 378, 437, 469};
  int c2[NHALF] = '{100, -50, 25, 0, 3, -7, 64, 200, -300, 12};

  // Accepted samples since the last reset (index 0 = oldest).
  int hist[$];

  // Observed transfers.
  logic [DATA_W-1:0] got_q[$];
  logic              got_sat_q[$];
  int                out_cyc_q[$];
  int                in_cyc_q[$];
  logic [DATA_W-1:0] exp_q[$];

  fir_sym_stream dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_sat     (out_sat),
    .coef_we     (coef_we),
    .coef_addr   (coef_addr),
    .coef_wdata  (coef_wdata),
    .coef_commit (coef_commit)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Inputs change just after posedge, so the negedge view equals what the
  // next posedge samples. Accept edge = cyc+1; output became valid at cyc.
  always @(negedge clk) begin
    if (!rst) begin
      if (in_valid && in_ready) in_cyc_q.push_back(cyc + 1);
      if (out_valid && out_ready) begin
        got_q.push_back(out_data);
        got_sat_q.push_back(out_sat);
        out_cyc_q.push_back(cyc);
      end
    end
  end

  // ---------------- reference model ----------------
  // Direct-form convolution over the accepted history with coefficient set c.
  function automatic void model_y(input int n, input int c[NHALF],
                                  output logic [DATA_W-1:0] y, output logic s);
    longint acc;
    acc = 0;
    for (int t = 0; t < NTAPS; t++) begin
      int h;
      h = (t < NHALF) ? c[t] : c[NTAPS-1-t];
      if (n - t >= 0) acc += longint'(hist[n-t]) * longint'(h);
    end
    acc = acc >>> SHIFT;
    s = 1'b0;
`ifdef FIR_SAT_EN
    if (acc > 32767) begin
      acc = 32767;
      s = 1'b1;
    end else if (acc < -32768) begin
      acc = -32768;
      s = 1'b1;
    end
`endif
    y = acc[DATA_W-1:0];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic clear_obs();
    got_q.delete();
    got_sat_q.delete();
    out_cyc_q.delete();
    in_cyc_q.delete();
    exp_q.delete();
  endtask

  // Entry and exit just after a posedge.
  task automatic send(input int x);
    int waited;
    waited = 0;
    in_valid = 1'b1;
    in_data  = DATA_W'(x);
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      n_checks++;
      $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, expected 1", waited);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    hist.push_back(x);
  endtask

  task automatic load_coefs(input int c[NHALF], input bit commit);
    for (int k = 0; k < NHALF; k++) begin
      coef_we    = 1'b1;
      coef_addr  = AW'(k);
      coef_wdata = COEF_W'(c[k]);
      @(posedge clk);
      #1;
    end
    coef_we = 1'b0;
    if (commit) begin
      coef_commit = 1'b1;
      @(posedge clk);
      #1;
      coef_commit = 1'b0;
    end
  endtask

  task automatic drain(input int n_expect, input string name);
    int waited;
    waited = 0;
    out_ready = 1'b1;
    while (got_q.size() < n_expect && waited < 200) begin
      @(posedge clk);
      waited++;
    end
    repeat (6) @(posedge clk);
    #1;
    n_checks++;
    if (got_q.size() != n_expect)
      $display("FAIL %s_count: got %0d outputs, expected %0d", name, got_q.size(), n_expect);
    else n_pass++;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL reset_hs: in_ready=%b out_valid=%b, expected 1/0", in_ready, out_valid);
    else n_pass++;
    rst = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (out_data !== '0 || out_sat !== 1'b0)
      $display("FAIL reset_data: out_data=%0d out_sat=%b, expected 0/0", out_data, out_sat);
    else n_pass++;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL reset_idle: in_ready=%b out_valid=%b, expected 1/0", in_ready, out_valid);
    else n_pass++;
  endtask

  // Impulse of 4096 = 1.0 after the 12-bit shift, so outputs are the taps.
  task automatic test_impulse();
    int exp_imp[21] = '{-21, 8, 34, 79, 143, 220, 302, 378, 437, 469,
                        469, 437, 378, 302, 220, 143, 79, 34, 8, -21, 0};
    load_coefs(c1, 1'b0);
    // Out-of-range shadow writes must not land anywhere.
    for (int a = NHALF; a < 16; a++) begin
      coef_we    = 1'b1;
      coef_addr  = AW'(a);
      coef_wdata = COEF_W'(999);
      @(posedge clk);
      #1;
    end
    coef_we     = 1'b0;
    coef_commit = 1'b1;
    @(posedge clk);
    #1;
    coef_commit = 1'b0;
    clear_obs();
    send(4096);
    for (int i = 0; i < 20; i++) send(0);
    drain(21, "impulse");
    foreach (exp_imp[i]) exp_q.push_back(DATA_W'(exp_imp[i]));
    for (int i = 0; i < 21; i++) begin
      n_checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i])
        $display("FAIL impulse[%0d]: got %0d, expected %0d", i,
                 (i < got_q.size()) ? $signed(got_q[i]) : 0, $signed(exp_q[i]));
      else n_pass++;
    end
    for (int i = 0; i < 21; i += 10) begin
      n_checks++;
      if (i >= out_cyc_q.size() || i >= in_cyc_q.size() || out_cyc_q[i] - in_cyc_q[i] != 3)
        $display("FAIL latency[%0d]: got %0d cycles, expected 3", i,
                 (i < out_cyc_q.size() && i < in_cyc_q.size()) ? out_cyc_q[i] - in_cyc_q[i] : -1);
      else n_pass++;
    end
  endtask

  // Coefficient sum is 2049: (100*2*2049) >>> 12 = 409800/4096 -> 100.
  task automatic test_constant();
    int base;
    logic [DATA_W-1:0] y;
    logic s;
    clear_obs();
    base = hist.size();
    for (int i = 0; i < 40; i++) send(100);
    drain(40, "constant");
    for (int i = 0; i < 19; i++) begin
      model_y(base + i, c1, y, s);
      n_checks++;
      if (i >= got_q.size() || got_q[i] !== y)
        $display("FAIL const_ramp[%0d]: got %0d, expected %0d", i,
                 (i < got_q.size()) ? $signed(got_q[i]) : 0, $signed(y));
      else n_pass++;
    end
    for (int i = 19; i < 40; i++) begin
      n_checks++;
      if (i >= got_q.size() || got_q[i] !== 16'd100)
        $display("FAIL const_steady[%0d]: got %0d, expected 100", i,
                 (i < got_q.size()) ? $signed(got_q[i]) : 0);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    int base;
    logic [DATA_W-1:0] held;
    logic [DATA_W-1:0] y;
    logic s;
    clear_obs();
    base = hist.size();
    fork
      for (int i = 0; i < 30; i++) send((i * 1237) % 7000 - 3500);
      begin
        repeat (10) @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        held = out_data;
        repeat (5) begin
          @(posedge clk);
          #1;
          n_checks++;
          if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== held)
            $display("FAIL stall_hold: in_ready=%b out_valid=%b out_data=%0d, expected 0/1/%0d",
                     in_ready, out_valid, $signed(out_data), $signed(held));
          else n_pass++;
        end
        out_ready = 1'b1;
      end
    join
    drain(30, "backpressure");
    for (int i = 0; i < 30; i++) begin
      model_y(base + i, c1, y, s);
      n_checks++;
      if (i >= got_q.size() || got_q[i] !== y)
        $display("FAIL bp_seq[%0d]: got %0d, expected %0d", i,
                 (i < got_q.size()) ? $signed(got_q[i]) : 0, $signed(y));
      else n_pass++;
    end
  endtask

  // Commit is asserted on the accept edge of sample 20; sample 18 enters
  // stage 2 on that edge (old set), sample 19 one edge later (new set).
  task automatic test_coef_switch();
    int base;
    logic [DATA_W-1:0] y;
    logic s;
    clear_obs();
    base = hist.size();
    fork
      for (int i = 0; i < 30; i++) begin
        if (i == 20) coef_commit = 1'b1;
        send(((i * 2711) % 6000) - 3000);
        coef_commit = 1'b0;
      end
      begin
        repeat (2) @(posedge clk);
        #1;
        load_coefs(c2, 1'b0);
      end
    join
    drain(30, "coef_switch");
    for (int i = 0; i < 30; i++) begin
      if (i >= 19) model_y(base + i, c2, y, s);
      else         model_y(base + i, c1, y, s);
      n_checks++;
      if (i >= got_q.size() || got_q[i] !== y)
        $display("FAIL coef_switch[%0d]: got %0d, expected %0d", i,
                 (i < got_q.size()) ? $signed(got_q[i]) : 0, $signed(y));
      else n_pass++;
    end
  endtask

  // 32767 everywhere, coefficients 2047: sum = 65534*2047*10 = 1341480980,
  // >>> 12 = 327510, which wraps to -170 (0xFF56) in 16 bits.
  task automatic test_saturation();
    int c_sat[NHALF];
    logic [DATA_W-1:0] exp_d;
    logic exp_s;
    foreach (c_sat[k]) c_sat[k] = 2047;
`ifdef FIR_SAT_EN
    exp_d = 16'h7FFF;
    exp_s = 1'b1;
`else
    exp_d = 16'hFF56;
    exp_s = 1'b0;
`endif
    load_coefs(c_sat, 1'b1);
    clear_obs();
    for (int i = 0; i < 25; i++) send(32767);
    drain(25, "saturation");
    for (int i = 19; i < 25; i++) begin
      n_checks++;
      if (i >= got_q.size() || got_q[i] !== exp_d || got_sat_q[i] !== exp_s)
        $display("FAIL sat[%0d]: got %0d/%b, expected %0d/%b", i,
                 (i < got_q.size()) ? $signed(got_q[i]) : 0,
                 (i < got_q.size()) ? got_sat_q[i] : 1'bx, $signed(exp_d), exp_s);
      else n_pass++;
    end
  endtask

  task automatic test_reset_midstream();
    int base;
    logic [DATA_W-1:0] y;
    logic s;
    load_coefs(c1, 1'b1);
    clear_obs();
    send(1000);
    send(2000);
    send(3000);
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== '0)
      $display("FAIL rst_async: out_valid=%b in_ready=%b out_data=%0d, expected 0/1/0",
               out_valid, in_ready, $signed(out_data));
    else n_pass++;
    clear_obs();
    hist.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 25; i++) send(500);
    drain(25, "post_reset");
    for (int i = 0; i < 25; i += 4) begin
      n_checks++;
      if (i >= got_q.size() || got_q[i] !== '0 || got_sat_q[i] !== 1'b0)
        $display("FAIL post_reset_zero[%0d]: got %0d, expected 0", i,
                 (i < got_q.size()) ? $signed(got_q[i]) : 0);
      else n_pass++;
    end
    load_coefs(c1, 1'b1);
    clear_obs();
    base = hist.size();
    send(4096);
    send(0);
    drain(2, "recommit");
    for (int i = 0; i < 2; i++) begin
      model_y(base + i, c1, y, s);
      n_checks++;
      if (i >= got_q.size() || got_q[i] !== y)
        $display("FAIL recommit[%0d]: got %0d, expected %0d", i,
                 (i < got_q.size()) ? $signed(got_q[i]) : 0, $signed(y));
      else n_pass++;
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst         = 1'b1;
    in_valid    = 1'b0;
    in_data     = '0;
    out_ready   = 1'b1;
    coef_we     = 1'b0;
    coef_addr   = '0;
    coef_wdata  = '0;
    coef_commit = 1'b0;
    test_reset();
    test_impulse();
    test_constant();
    test_backpressure();
    test_coef_switch();
    test_saturation();
    test_reset_midstream();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
